// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports:
//   clk            in   1  single clock, rising edge
//   rst            in   1  synchronous active-low reset
//   mem_addr       in  30  core data word address
//   mem_write      in   1  core store strobe
//   mem_write_data in  32  core store data
//   sel            out  1  mem_addr hits TXDATA or STATUS (combinational)
//   rd_data        out 32  read data for the window, 0 when sel=0 (combinational)
//   txd            out  1  serial line, registered, idle high
//   busy           out  1  registered: serializer active or FIFO non-empty
//
// Register window (word addresses):
//   BASE_ADDR   TXDATA  write pushes byte [7:0]; reads 0
//   BASE_ADDR+1 STATUS  {count[15:8], overflow[3], busy[2], empty[1], full[0]};
//                       writing bit3=1 clears the sticky overflow flag
module mmio_uart_tx #(
  parameter logic [29:0] BASE_ADDR    = 30'h3FFF_FFF0,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_write_data,
  output logic        sel,
  output logic [31:0] rd_data,
  output logic        txd,
  output logic        busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  localparam logic [29:0]    STATUS_ADDR = BASE_ADDR + 30'd1;
  localparam logic [CW-1:0]  DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BCW-1:0] LAST_CNT    = BCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q;
  logic [BCW-1:0] bitCnt_q;
  logic [2:0]     bitIdx_q;
  logic [7:0]     shift_q;
  logic           txd_q;
  logic           busy_q;

  logic [7:0]     fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]  rdPtr_q, rdPtr_d;
  logic [PW-1:0]  wrPtr_q, wrPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;

  logic           hitData, hitStatus;
  logic           fifoFull, fifoEmpty;
  logic           pushReq, pushEn, popEn;
  logic [7:0]     headByte;
  logic           unusedWriteData;

  assign hitData   = (mem_addr == BASE_ADDR);
  assign hitStatus = (mem_addr == STATUS_ADDR);
  assign sel       = hitData || hitStatus;

  assign fifoFull  = (count_q == DEPTH_C);
  assign fifoEmpty = (count_q == '0);
  assign headByte  = fifoMem_q[rdPtr_q];

  // A store to a full FIFO is dropped even if the serializer pops on the
  // same edge; the decision uses the count before that edge.
  assign pushReq = mem_write && hitData;
  assign pushEn  = pushReq && !fifoFull;

  // The serializer takes a byte when idle, or at the last cycle of a stop
  // bit so consecutive frames run with no idle gap.
  assign popEn = !fifoEmpty &&
                 ((state_q == IDLE) || ((state_q == STOP) && (bitCnt_q == LAST_CNT)));

  assign unusedWriteData = ^mem_write_data[31:8];

  always_comb begin
    wrPtr_d    = pushEn ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d    = popEn  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d    = count_q + CW'(pushEn) - CW'(popEn);
    overflow_d = overflow_q;
    if (pushReq && fifoFull) begin
      overflow_d = 1'b1;
    end else if (mem_write && hitStatus && mem_write_data[3]) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem_q[wrPtr_q] <= mem_write_data[7:0];
    end
  end

  // Serializer. txd and busy are produced alongside each state transition so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bitCnt_q <= '0;
          if (popEn) begin
            shift_q <= headByte;
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START: begin
          busy_q <= 1'b1;
          if (bitCnt_q == LAST_CNT) begin
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= DATA;
            txd_q    <= shift_q[0];
          end else begin
            bitCnt_q <= bitCnt_q + BCW'(1);
          end
        end
        DATA: begin
          busy_q <= 1'b1;
          if (bitCnt_q == LAST_CNT) begin
            bitCnt_q <= '0;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              txd_q    <= shift_q[bitIdx_q + 3'd1];
            end
          end else begin
            bitCnt_q <= bitCnt_q + BCW'(1);
          end
        end
        STOP: begin
          if (bitCnt_q == LAST_CNT) begin
            bitCnt_q <= '0;
            if (popEn) begin
              shift_q <= headByte;
              state_q <= START;
              txd_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            bitCnt_q <= bitCnt_q + BCW'(1);
            busy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (hitStatus) begin
      rd_data[0]       = fifoFull;
      rd_data[1]       = fifoEmpty;
      rd_data[2]       = busy_q;
      rd_data[3]       = overflow_q;
      rd_data[8 +: CW] = count_q;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Stores push the expected byte and its expected start cycle;
// a monitor decodes every frame seen on txd and compares it against the queue.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [29:0] BASE  = 30'h3FFF_FFF0;
  localparam logic [29:0] STAT  = BASE + 30'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] memAddr = '0;
  logic        memWrite = 1'b0;
  logic [31:0] memWriteData = '0;
  logic        sel;
  logic [31:0] rdData;
  logic        txd;
  logic        busy;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (memAddr),
    .mem_write      (memWrite),
    .mem_write_data (memWriteData),
    .sel            (sel),
    .rd_data        (rdData),
    .txd            (txd),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         startCycle;
  } frame_t;

  frame_t expQ[$];
  int     total = 0;
  int     bad = 0;
  int     cycleCnt = 0;
  int     resetEdges = 0;
  int     handledResets = 0;
  int     lastExpStart = -1000;

  logic        monBusy = 1'b0;
  int          monK = 0;
  int          monStart = 0;
  logic [39:0] monBits = '0;

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (rst === 1'b0) resetEdges <= resetEdges + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Drives one bus cycle from a negedge and returns at the following negedge.
  // When a push is expected, the byte starts one edge after the store, or
  // right after the previous expected frame if that one is still running.
  task automatic applyStimulus(input logic [29:0] addr, input logic [31:0] data,
                               input logic wr, input logic expectPush);
    frame_t f;
    int     pushEdge;
    memAddr      = addr;
    memWrite     = wr;
    memWriteData = data;
    pushEdge     = cycleCnt + 1;
    if (expectPush) begin
      f.data       = data[7:0];
      f.startCycle = (pushEdge + 1 > lastExpStart + 10 * CPB) ? pushEdge + 1
                                                              : lastExpStart + 10 * CPB;
      lastExpStart = f.startCycle;
      expQ.push_back(f);
    end
    @(negedge clk);
    memWrite = 1'b0;
  endtask

  task automatic finishFrame();
    frame_t      f;
    logic [39:0] expBits;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected frame: got bits %h at cycle %0d, required none", monBits, monStart);
    end else begin
      f = expQ.pop_front();
      for (int k = 0; k < 40; k++) begin
        if (k < CPB)            expBits[k] = 1'b0;
        else if (k >= 9 * CPB)  expBits[k] = 1'b1;
        else                    expBits[k] = f.data[(k / CPB) - 1];
      end
      checkOutput("frame bits", {24'h0, monBits}, {24'h0, expBits});
      checkOutput("frame start cycle", 64'(monStart), 64'(f.startCycle));
    end
  endtask

  // Monitor: one txd sample per cycle; a low level on an idle line opens a
  // 40-sample frame. A reset edge abandons any frame and all queued bytes.
  always @(negedge clk) begin
    if (resetEdges != handledResets) begin
      handledResets = resetEdges;
      monBusy = 1'b0;
      expQ.delete();
    end else if (monBusy) begin
      monBits[monK] = txd;
      monK++;
      if (monK == 10 * CPB) begin
        monBusy = 1'b0;
        finishFrame();
      end
    end else if (rst === 1'b1 && txd === 1'b0) begin
      monBusy    = 1'b1;
      monStart   = cycleCnt;
      monBits    = '0;
      monBits[0] = txd;
      monK       = 1;
    end
  end

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || monBusy) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {63'h0, (expQ.size() != 0 || monBusy)}, 64'h0);
  endtask

  task automatic readStatus(input string name, input logic [31:0] expected);
    memAddr = STAT;
    #1;
    checkOutput(name, {32'h0, rdData}, {32'h0, expected});
  endtask

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n0;
    int glitches;
    logic [7:0] ovfBytes [6];
    ovfBytes = '{8'h3C, 8'hC3, 8'h5A, 8'h81, 8'h7E, 8'h99};

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("reset txd", {63'h0, txd}, 64'h1);
    checkOutput("reset busy", {63'h0, busy}, 64'h0);
    readStatus("reset status", 32'h0000_0002);
    checkOutput("reset sel", {63'h0, sel}, 64'h1);

    // Single byte A5: start bit one edge after the store, busy drops at N+41.
    $display("[TB] single byte");
    @(negedge clk);
    applyStimulus(BASE, 32'hFFFF_FFA5, 1'b1, 1'b1);
    n0 = cycleCnt;
    checkOutput("busy at N", {63'h0, busy}, 64'h0);
    checkOutput("txd at N", {63'h0, txd}, 64'h1);
    @(negedge clk);
    checkOutput("txd at N+1", {63'h0, txd}, 64'h0);
    checkOutput("busy at N+1", {63'h0, busy}, 64'h1);
    while (cycleCnt < n0 + 40) @(negedge clk);
    checkOutput("busy at N+40", {63'h0, busy}, 64'h1);
    @(negedge clk);
    checkOutput("busy at N+41", {63'h0, busy}, 64'h0);
    checkOutput("txd at N+41", {63'h0, txd}, 64'h1);
    waitDrain("single drain", 20);

    // Back-to-back 00 then FF: second frame starts 40 cycles after the first.
    $display("[TB] back-to-back");
    applyStimulus(BASE, 32'h0000_0000, 1'b1, 1'b1);
    applyStimulus(BASE, 32'h0000_00FF, 1'b1, 1'b1);
    readStatus("b2b status count=1", 32'h0000_0104);
    waitDrain("b2b drain", 150);

    // Six stores into a 4-deep FIFO: first popped, four queued, last dropped.
    $display("[TB] full/overflow");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(BASE, {24'hABCDEF, ovfBytes[i]}, 1'b1, i < 5);
    end
    readStatus("overflow status", 32'h0000_040D);
    applyStimulus(STAT, 32'h0000_0008, 1'b1, 1'b0);
    readStatus("overflow cleared", 32'h0000_0405);
    waitDrain("overflow drain", 300);
    readStatus("after overflow idle", 32'h0000_0002);

    // Decode: neighbouring addresses do not alias.
    $display("[TB] decode");
    applyStimulus(BASE + 30'd2, 32'h0000_0055, 1'b1, 1'b0);
    memAddr = BASE + 30'd2;
    #1;
    checkOutput("sel base+2", {63'h0, sel}, 64'h0);
    checkOutput("rd base+2", {32'h0, rdData}, 64'h0);
    memAddr = BASE - 30'd1;
    #1;
    checkOutput("sel base-1", {63'h0, sel}, 64'h0);
    memAddr = BASE;
    #1;
    checkOutput("sel base", {63'h0, sel}, 64'h1);
    checkOutput("rd txdata", {32'h0, rdData}, 64'h0);
    readStatus("no push from base+2", 32'h0000_0002);
    @(negedge clk);
    checkOutput("busy after base+2", {63'h0, busy}, 64'h0);

    // Reset during data bit 3 of the first frame with two bytes queued.
    $display("[TB] reset mid-frame");
    applyStimulus(BASE, 32'h0000_0008, 1'b1, 1'b1);
    applyStimulus(BASE, 32'h0000_0033, 1'b1, 1'b1);
    applyStimulus(BASE, 32'h0000_0044, 1'b1, 1'b1);
    n0 = cycleCnt - 2;
    readStatus("two queued", 32'h0000_0204);
    while (cycleCnt < n0 + 17) @(negedge clk);
    checkOutput("data bit3", {63'h0, txd}, 64'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lastExpStart = -1000;
    checkOutput("mid reset txd", {63'h0, txd}, 64'h1);
    checkOutput("mid reset busy", {63'h0, busy}, 64'h0);
    readStatus("mid reset status", 32'h0000_0002);
    glitches = 0;
    repeat (120) begin
      @(negedge clk);
      if (txd !== 1'b1) glitches++;
    end
    checkOutput("line idle after reset", 64'(glitches), 64'h0);
    checkOutput("scoreboard empty", 64'(expQ.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the `riscv` core's data-memory port (`mem_addr`, `mem_write`, `mem_write_data`).
- Stores to its register window push bytes into a TX FIFO; a serializer sends them 8N1, LSB first, on `txd`.
- Loads from the window return status through a combinational `rd_data`/`sel` pair; top level muxes that into the core's `mem_read_data`.

Parameters:
- BASE_ADDR, 30'h3FFF_FFF0, word address of TXDATA. STATUS is at BASE_ADDR+1.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Minimum 2.
- FIFO_DEPTH, 8, TX FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge resets the block
- mem_addr  in  30  core data word address
- mem_write  in  1  core store strobe
- mem_write_data  in  32  core store data
- sel  out  1  combinational: mem_addr is TXDATA or STATUS
- rd_data  out  32  combinational read data, valid when sel=1
- txd  out  1  serial output, registered, idle high
- busy  out  1  registered: serializer not IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0 at an edge) forces the following on that edge:
  - txd=1, busy=0, FSM=IDLE
  - FIFO count=0, read/write pointers=0, overflow=0
  - Applies mid-frame too: the frame is abandoned and txd is high after that edge.
- Address decode:
  - Exact word match only; no other addresses alias.
  - sel=1 iff mem_addr equals BASE_ADDR or BASE_ADDR+1.
- TXDATA write (mem_write=1, addr=BASE_ADDR):
  - Pushes mem_write_data[7:0]; bits [31:8] ignored.
  - If count==FIFO_DEPTH at that edge, the byte is dropped and overflow is set (sticky). This holds even when a pop happens on the same edge.
  - Push and pop on the same edge when not full: count is unchanged.
- STATUS write (addr=BASE_ADDR+1): if mem_write_data[3]=1, overflow is cleared. All other bits are ignored.
- Reads (combinational from current state):
  - TXDATA reads 0.
  - STATUS bits:
    - bit0 full (count==FIFO_DEPTH)
    - bit1 empty (count==0)
    - bit2 busy
    - bit3 overflow
    - bits[15:8] count, zero-extended
    - all other bits 0
  - rd_data is 0 when sel=0.
- Serializer FSM (IDLE, START, DATA, STOP):
  - Bit-cycle counter runs 0..CLKS_PER_BIT-1; a 3-bit index selects the data bit.
  - IDLE: txd=1. If the FIFO is non-empty at an edge: pop the head into the shift register, go to START, and drive txd=0 from that edge.
  - Latency: a byte pushed into an empty FIFO while IDLE at edge N shows txd=0 from edge N+1.
  - START: hold 0 for CLKS_PER_BIT cycles, then DATA with index 0.
  - DATA: txd=shift[index] for CLKS_PER_BIT cycles each; after index 7 go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At its last cycle:
    - If the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy:
  - Set on the edge after the FIFO becomes non-empty.
  - Cleared on the edge the FSM returns to IDLE with an empty FIFO.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Non-window stores and all loads have no side effects.

Test Plan:
- Reset and idle:
  - Hold rst=0 for 3 edges, then release → txd=1, busy=0.
  - STATUS read = 32'h0000_0002 (empty).
- Single byte (CLKS_PER_BIT=4):
  - Store 32'hFFFF_FFA5 to TXDATA at edge N.
  - txd=0 for edges N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Then stop=1 for 4 cycles.
  - busy falls at edge N+41.
- Back-to-back:
  - Store 8'h00 then 8'hFF on consecutive cycles.
  - Second start bit begins exactly 40 cycles after the first; no idle cycle between frames.
  - STATUS count reads 1 during the first frame.
- Full/overflow (FIFO_DEPTH=4, CLKS_PER_BIT=4):
  - Store 6 bytes on consecutive cycles.
  - Entry 1 is popped, 4 are queued, entry 6 is dropped.
  - STATUS = full=1, overflow=1, count=4.
  - Store 32'h8 to STATUS → overflow=0, all other bits unchanged.
  - Exactly 5 frames appear on txd.
- Decode:
  - Store to BASE_ADDR+2 → no push, sel=0, rd_data=0.
  - Load BASE_ADDR → rd_data=0, sel=1.
- Reset mid-frame:
  - Assert rst=0 for one edge during DATA bit 3 with 2 bytes queued.
  - Result: txd=1, busy=0, count=0, overflow=0.
  - No further frames are sent.
